// File: rtl/ctrl_decode_stage_pkg.sv
// Shared definitions for the registered control decode stage: opcode/function
// encodings, ALU operations, FSM states and the control bundle payload.
package ctrl_decode_stage_pkg;

   localparam int unsigned INSTR_W   = 9;
   localparam int unsigned OPFUN_W   = 5;
   localparam int unsigned ALU_OP_W  = 4;
   localparam int unsigned ALU_SRC_W = 2;
   localparam int unsigned SEL_W     = 2;
   localparam int unsigned CNT_W     = 4;

   typedef enum logic [2:0] {
      OP_REG   = 3'b000,
      OP_ARITH = 3'b001,
      OP_SHIFT = 3'b010,
      OP_HARD  = 3'b011,
      OP_SLT   = 3'b100,
      OP_XOR   = 3'b101,
      OP_AND   = 3'b110,
      OP_OR    = 3'b111
   } op_code_t;

   typedef enum logic [1:0] {
      FN_LW     = 2'b00,
      FN_SW     = 2'b01,
      FN_BRANCH = 2'b10,
      FN_REDEF  = 2'b11
   } func_code_t;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SHIFTL = 4'd2,
      ALU_SHIFTR = 4'd3,
      ALU_SLB    = 4'd4,
      ALU_BNZ    = 4'd5,
      ALU_SLT    = 4'd6,
      ALU_XOR    = 4'd7,
      ALU_AND    = 4'd8,
      ALU_OR     = 4'd9
   } alu_op_t;

   typedef enum logic {
      RUN       = 1'b0,
      LOAD_WAIT = 1'b1
   } dec_state_t;

   typedef struct packed {
      logic                 reg_imm;
      logic                 reg_write_src;
      logic                 mem_write;
      logic                 mem_read;
      logic                 reg_write;
      logic                 reg_read_write;
      logic                 reg_write_read;
      logic                 is_branch;
      alu_op_t              alu_op;
      logic [ALU_SRC_W-1:0] alu_src;
   } ctrl_bundle_t;

   localparam logic [SEL_W-1:0] REDEF_RESTORE = 2'b11;

endpackage

// File: rtl/ctrl_decode_stage_comb.sv
// Pure combinational decode table: opcode/function field -> control bundle,
// plus the LW and REDEF classification the stage needs for its own bookkeeping.
module ctrl_decode_comb
   import ctrl_decode_stage_pkg::*;
(
   input  logic [OPFUN_W-1:0] op_fun,
   output ctrl_bundle_t       ctrl_c,
   output logic               lw_c,
   output logic               redef_c
);

   op_code_t   op;
   func_code_t fun2;
   logic       fun1;

   assign op   = op_code_t'(op_fun[4:2]);
   assign fun2 = func_code_t'(op_fun[1:0]);
   assign fun1 = op_fun[1];

   always_comb begin
      ctrl_c  = '0;
      lw_c    = 1'b0;
      redef_c = 1'b0;
      case (op)
         OP_REG: begin
            ctrl_c.reg_write = 1'b1;
            ctrl_c.alu_src   = 2'b01;
            ctrl_c.alu_op    = ALU_SLB;
         end
         OP_ARITH, OP_SHIFT: begin
            ctrl_c.reg_imm        = 1'b1;
            ctrl_c.reg_read_write = 1'b1;
            ctrl_c.reg_write_read = 1'b1;
            ctrl_c.reg_write      = 1'b1;
            if (op == OP_ARITH) ctrl_c.alu_op = fun1 ? ALU_SUB : ALU_ADD;
            else                ctrl_c.alu_op = fun1 ? ALU_SHIFTR : ALU_SHIFTL;
         end
         OP_HARD: begin
            case (fun2)
               FN_LW: begin
                  ctrl_c.reg_read_write = 1'b1;
                  ctrl_c.reg_write      = 1'b1;
                  ctrl_c.mem_read       = 1'b1;
                  ctrl_c.reg_write_src  = 1'b1;
                  lw_c                  = 1'b1;
               end
               FN_SW: begin
                  ctrl_c.reg_write_read = 1'b1;
                  ctrl_c.mem_write      = 1'b1;
               end
               FN_BRANCH: begin
                  ctrl_c.reg_write_read = 1'b1;
                  ctrl_c.alu_op         = ALU_BNZ;
                  ctrl_c.alu_src        = 2'b10;
                  ctrl_c.is_branch      = 1'b1;
               end
               default: redef_c = 1'b1;
            endcase
         end
         default: begin
            // SLT/XOR/AND/OR share one shape; only the ALU operation differs
            ctrl_c.reg_write_read = 1'b1;
            ctrl_c.reg_write      = 1'b1;
            ctrl_c.alu_src        = 2'b10;
            case (op)
               OP_SLT:  ctrl_c.alu_op = ALU_SLT;
               OP_XOR:  ctrl_c.alu_op = ALU_XOR;
               OP_AND:  ctrl_c.alu_op = ALU_AND;
               default: ctrl_c.alu_op = ALU_OR;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: valid/ready intake, one-deep control bundle register,
// internal register-window pointers, LW stall FSM and branch flush.
module ctrl_decode_stage
   import ctrl_decode_stage_pkg::*;
#(
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned PAW      = 2,
   parameter int unsigned R0_DEF   = 0,
   parameter int unsigned R1_DEF   = 1,
   parameter int unsigned W_DEF    = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [8:0]     instr,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [PAW-1:0] r0_sel,
   output logic [PAW-1:0] r1_sel,
   output logic [PAW-1:0] w_sel,
   output logic           reg_imm,
   output logic           reg_write_src,
   output logic           mem_write,
   output logic           mem_read,
   output logic           reg_write,
   output logic           reg_read_write,
   output logic           reg_write_read,
   output logic           is_branch,
   output logic [3:0]     alu_op,
   output logic [1:0]     alu_src
);

   dec_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q;
   ctrl_bundle_t     ctrl_q, dec_ctrl;
   logic             dec_lw, dec_redef;
   logic             accept;
   logic [SEL_W-1:0] redef_sel;
   logic [PAW-1:0]   redef_val;
   logic [PAW-1:0]   r0_win_q, r1_win_q, w_win_q;
   logic [PAW-1:0]   r0_sel_q, r1_sel_q, w_sel_q;

   ctrl_decode_comb u_decode (
      .op_fun  (instr[8:4]),
      .ctrl_c  (dec_ctrl),
      .lw_c    (dec_lw),
      .redef_c (dec_redef)
   );

   assign in_ready  = !reset && (state_q == RUN) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign redef_sel = instr[3:2];
   assign redef_val = instr[PAW-1:0];

   // Load-wait FSM: LOAD_LAT blocked cycles follow an accepted LW
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (accept && dec_lw && (LOAD_LAT != 0)) begin
               state_d = LOAD_WAIT;
               cnt_d   = CNT_W'(LOAD_LAT);
            end
         end
         LOAD_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RUN;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
      if (flush) begin
         state_d = RUN;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Bundle register; window pointers are captured alongside the bundle
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         ctrl_q      <= '0;
         r0_sel_q    <= '0;
         r1_sel_q    <= '0;
         w_sel_q     <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (accept && !dec_redef) begin
         out_valid_q <= 1'b1;
         ctrl_q      <= dec_ctrl;
         r0_sel_q    <= r0_win_q;
         r1_sel_q    <= r1_win_q;
         w_sel_q     <= w_win_q;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r0_win_q <= PAW'(R0_DEF);
         r1_win_q <= PAW'(R1_DEF);
         w_win_q  <= PAW'(W_DEF);
      end else if (accept && dec_redef && !flush) begin
         case (redef_sel)
            2'b00: r0_win_q <= redef_val;
            2'b01: r1_win_q <= redef_val;
            2'b10: w_win_q  <= redef_val;
            REDEF_RESTORE: begin
               r0_win_q <= PAW'(R0_DEF);
               r1_win_q <= PAW'(R1_DEF);
               w_win_q  <= PAW'(W_DEF);
            end
            default: ;
         endcase
      end
   end

   assign out_valid      = out_valid_q;
   assign r0_sel         = r0_sel_q;
   assign r1_sel         = r1_sel_q;
   assign w_sel          = w_sel_q;
   assign reg_imm        = ctrl_q.reg_imm;
   assign reg_write_src  = ctrl_q.reg_write_src;
   assign mem_write      = ctrl_q.mem_write;
   assign mem_read       = ctrl_q.mem_read;
   assign reg_write      = ctrl_q.reg_write;
   assign reg_read_write = ctrl_q.reg_read_write;
   assign reg_write_read = ctrl_q.reg_write_read;
   assign is_branch      = ctrl_q.is_branch;
   assign alu_op         = ctrl_q.alu_op;
   assign alu_src        = ctrl_q.alu_src;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: directed scenarios plus a random
// run, all checked against a cycle-level behavioural model of the stage.
module tb_ctrl_decode_stage;

   localparam int unsigned LAT = 3;

   logic       clk = 1'b0;
   logic       reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [8:0] instr;
   logic [1:0] r0_sel, r1_sel, w_sel, alu_src;
   logic [3:0] alu_op;
   logic       reg_imm, reg_write_src, mem_write, mem_read;
   logic       reg_write, reg_read_write, reg_write_read, is_branch;
   logic [19:0] obs;

   int n_pass = 0;
   int n_total = 0;

   // Model state
   bit          m_ov;
   logic [19:0] m_out;
   int          win0, win1, win2, stall;
   bit          exp_rdy;

   always #5 clk = ~clk;

   ctrl_decode_stage #(
      .LOAD_LAT(LAT), .PAW(2), .R0_DEF(0), .R1_DEF(1), .W_DEF(2)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .r0_sel(r0_sel), .r1_sel(r1_sel), .w_sel(w_sel),
      .reg_imm(reg_imm), .reg_write_src(reg_write_src), .mem_write(mem_write),
      .mem_read(mem_read), .reg_write(reg_write), .reg_read_write(reg_read_write),
      .reg_write_read(reg_write_read), .is_branch(is_branch),
      .alu_op(alu_op), .alu_src(alu_src)
   );

   assign obs = {reg_imm, reg_write_src, mem_write, mem_read, reg_write,
                 reg_read_write, reg_write_read, is_branch, alu_op, alu_src,
                 r0_sel, r1_sel, w_sel};

   // Flags {imm,wsrc,mw,mr,rw,rrw,rwr,br}, alu op number, alu source
   function automatic logic [13:0] ref_decode(input logic [8:0] ins);
      int op, f2, alu, src;
      bit f1;
      logic [7:0] fl;
      op = int'(ins[8:6]); f1 = ins[5]; f2 = int'(ins[5:4]);
      fl = 8'b0; alu = 0; src = 0;
      case (op)
         0: begin fl = 8'b0000_1000; src = 1; alu = 4; end
         1, 2: begin fl = 8'b1000_1110; alu = (op == 1 ? 0 : 2) + (f1 ? 1 : 0); end
         3: case (f2)
               0: fl = 8'b0101_1100;
               1: fl = 8'b0010_0010;
               2: begin fl = 8'b0000_0011; alu = 5; src = 2; end
               default: fl = 8'b0;
            endcase
         default: begin fl = 8'b0000_1010; src = 2; alu = 6 + op - 4; end
      endcase
      return {fl, 4'(alu), 2'(src)};
   endfunction

   task automatic set_in(input bit v, input logic [8:0] ins, input bit ordy,
                         input bit fl, input bit rst);
      reset = rst; in_valid = v; instr = ins; out_ready = ordy; flush = fl;
      exp_rdy = !rst && (stall == 0) && (!m_ov || ordy);
      #1;
   endtask

   // Advance the model over the coming edge, then wait for the next sample point
   task automatic tick();
      bit acc;
      if (reset) begin
         m_ov = 0; m_out = '0; win0 = 0; win1 = 1; win2 = 2; stall = 0;
      end else begin
         acc = in_valid && exp_rdy;
         if (flush) begin
            m_ov = 0; stall = 0;
         end else if (acc && instr[8:4] == 5'b011_11) begin
            case (int'(instr[3:2]))
               0: win0 = int'(instr[1:0]);
               1: win1 = int'(instr[1:0]);
               2: win2 = int'(instr[1:0]);
               default: begin win0 = 0; win1 = 1; win2 = 2; end
            endcase
            if (out_ready) m_ov = 0;
         end else if (acc) begin
            m_out = {ref_decode(instr), 2'(win0), 2'(win1), 2'(win2)};
            m_ov  = 1;
            if (instr[8:4] == 5'b011_00) stall = LAT;
         end else begin
            if (out_ready) m_ov = 0;
            if (stall > 0) stall--;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      set_in(0, 9'd0, 0, 0, 1);
      n_total++; if (in_ready !== 1'b0) $display("FAIL reset_rdy: got %b want 0", in_ready); else n_pass++;
      tick(); tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_ov: got %b want 0", out_valid); else n_pass++;
      n_total++; if (obs !== 20'd0) $display("FAIL reset_bundle: got %h want 0", obs); else n_pass++;
      set_in(0, 9'd0, 1, 0, 0);
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_rdy_rel: got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_arith();
      set_in(1, 9'b001_0_00000, 1, 0, 0);
      tick();
      n_total++; if (out_valid !== 1'b1) $display("FAIL arith_ov: got %b want 1", out_valid); else n_pass++;
      n_total++; if (obs !== {8'b1000_1110, 4'd0, 2'b00, 2'd0, 2'd1, 2'd2})
         $display("FAIL arith_bundle: got %h want %h", obs, {8'b1000_1110, 4'd0, 2'b00, 2'd0, 2'd1, 2'd2}); else n_pass++;
      n_total++; if (obs !== m_out) $display("FAIL arith_model: got %h want %h", obs, m_out); else n_pass++;
   endtask

   task automatic test_redef();
      set_in(1, 9'b011_11_01_11, 1, 0, 0);
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL redef_nobundle: got %b want 0", out_valid); else n_pass++;
      set_in(1, 9'b110_000000, 1, 0, 0);
      tick();
      n_total++; if ({out_valid, r1_sel, alu_src, alu_op} !== {1'b1, 2'd3, 2'b10, 4'd8})
         $display("FAIL redef_and: got %b want %b", {out_valid, r1_sel, alu_src, alu_op}, {1'b1, 2'd3, 2'b10, 4'd8}); else n_pass++;
      n_total++; if (obs !== m_out) $display("FAIL redef_and_model: got %h want %h", obs, m_out); else n_pass++;
      set_in(1, 9'b011_11_11_00, 1, 0, 0);
      tick();
      set_in(1, 9'b101_000000, 1, 0, 0);
      tick();
      n_total++; if ({out_valid, r0_sel, r1_sel, w_sel} !== 7'b1_00_01_10)
         $display("FAIL redef_restore: got %b want 1000110", {out_valid, r0_sel, r1_sel, w_sel}); else n_pass++;
   endtask

   task automatic test_load_wait();
      set_in(1, 9'b011_00_0000, 1, 0, 0);
      n_total++; if (in_ready !== 1'b1) $display("FAIL lw_accept_rdy: got %b want 1", in_ready); else n_pass++;
      tick();
      n_total++; if ({out_valid, mem_read, reg_write_src} !== 3'b111)
         $display("FAIL lw_bundle: got %b want 111", {out_valid, mem_read, reg_write_src}); else n_pass++;
      for (int i = 1; i <= 3; i++) begin
         set_in(1, 9'b111_000000, 1, 0, 0);
         n_total++; if (in_ready !== 1'b0) $display("FAIL lw_stall_%0d: got %b want 0", i, in_ready); else n_pass++;
         tick();
      end
      set_in(1, 9'b111_000000, 1, 0, 0);
      n_total++; if (in_ready !== 1'b1) $display("FAIL lw_resume: got %b want 1", in_ready); else n_pass++;
      tick();
      n_total++; if (obs !== m_out || out_valid !== 1'b1) $display("FAIL lw_next: got %h want %h", obs, m_out); else n_pass++;
   endtask

   task automatic test_backpressure();
      set_in(1, 9'b101_000000, 1, 0, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 9'b100_000000, 0, 0, 0);
         n_total++; if (in_ready !== 1'b0) $display("FAIL bp_rdy_%0d: got %b want 0", i, in_ready); else n_pass++;
         tick();
         n_total++; if ({out_valid, obs} !== {1'b1, 8'b0000_1010, 4'd7, 2'b10, 6'b00_01_10})
            $display("FAIL bp_hold_%0d: got %h want %h", i, {out_valid, obs}, {1'b1, 8'b0000_1010, 4'd7, 2'b10, 6'b00_01_10}); else n_pass++;
      end
      set_in(1, 9'b100_000000, 1, 0, 0);
      n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", in_ready); else n_pass++;
      tick();
      n_total++; if ({out_valid, obs} !== {1'b1, 8'b0000_1010, 4'd6, 2'b10, 6'b00_01_10})
         $display("FAIL bp_swap: got %h want %h", {out_valid, obs}, {1'b1, 8'b0000_1010, 4'd6, 2'b10, 6'b00_01_10}); else n_pass++;
   endtask

   task automatic test_flush();
      set_in(1, 9'b011_00_0000, 1, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 9'd0, 0, 0, 0);
         tick();
      end
      set_in(1, 9'b011_11_00_11, 1, 1, 0);
      n_total++; if (in_ready !== 1'b1) $display("FAIL flush_rdy: got %b want 1", in_ready); else n_pass++;
      tick();
      n_total++; if (out_valid !== 1'b0) $display("FAIL flush_ov: got %b want 0", out_valid); else n_pass++;
      set_in(1, 9'b110_000000, 1, 0, 0);
      n_total++; if (in_ready !== 1'b1) $display("FAIL flush_run: got %b want 1", in_ready); else n_pass++;
      tick();
      n_total++; if ({out_valid, r0_sel, r1_sel, w_sel} !== 7'b1_00_01_10)
         $display("FAIL flush_windows: got %b want 1000110", {out_valid, r0_sel, r1_sel, w_sel}); else n_pass++;
      // Flushed LW must not start a load wait
      set_in(1, 9'b011_00_0000, 1, 1, 0);
      tick();
      set_in(1, 9'b110_000000, 1, 0, 0);
      n_total++; if (in_ready !== 1'b1) $display("FAIL flush_lw_nowait: got %b want 1", in_ready); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_wait();
      set_in(1, 9'b011_11_10_00, 1, 0, 0);
      tick();
      set_in(1, 9'b011_00_0000, 1, 0, 0);
      tick();
      set_in(0, 9'd0, 1, 0, 0);
      n_total++; if (in_ready !== 1'b0) $display("FAIL rmw_stall: got %b want 0", in_ready); else n_pass++;
      tick();
      set_in(0, 9'd0, 1, 0, 1);
      tick();
      n_total++; if ({out_valid, obs} !== 21'd0) $display("FAIL rmw_cleared: got %h want 0", {out_valid, obs}); else n_pass++;
      set_in(1, 9'b001_0_00000, 1, 0, 0);
      n_total++; if (in_ready !== 1'b1) $display("FAIL rmw_rdy: got %b want 1", in_ready); else n_pass++;
      tick();
      n_total++; if ({out_valid, r0_sel, r1_sel, w_sel} !== 7'b1_00_01_10)
         $display("FAIL rmw_windows: got %b want 1000110", {out_valid, r0_sel, r1_sel, w_sel}); else n_pass++;
   endtask

   task automatic test_random();
      logic [8:0] ins;
      bit v, ordy, fl, rst;
      for (int i = 0; i < 600; i++) begin
         rst  = ($urandom % 64) == 0;
         fl   = ($urandom % 8) == 0;
         v    = ($urandom % 4) != 0;
         ordy = ($urandom % 4) != 0;
         ins  = 9'($urandom);
         if (($urandom % 3) == 0) ins[8:6] = 3'b011;
         set_in(v, ins, ordy, fl, rst);
         n_total++; if (in_ready !== exp_rdy) $display("FAIL rnd_rdy_%0d: got %b want %b", i, in_ready, exp_rdy); else n_pass++;
         tick();
         n_total++; if (out_valid !== m_ov) $display("FAIL rnd_ov_%0d: got %b want %b", i, out_valid, m_ov); else n_pass++;
         if (m_ov) begin
            n_total++; if (obs !== m_out) $display("FAIL rnd_bundle_%0d: got %h want %h", i, obs, m_out); else n_pass++;
         end
      end
   endtask

   initial begin
      reset = 1; in_valid = 0; instr = '0; out_ready = 0; flush = 0;
      m_ov = 0; m_out = '0; win0 = 0; win1 = 1; win2 = 2; stall = 0; exp_rdy = 0;
      @(negedge clk);
      test_reset();
      test_arith();
      test_redef();
      test_load_wait();
      test_backpressure();
      test_flush();
      test_reset_mid_wait();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
      $fatal(1);
   end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered, stateful successor to the combinational R.O.E instruction decoder.
- Sits between fetch and the register file/ALU. Accepts 9-bit instructions over a valid/ready handshake and emits a registered control bundle one cycle later.
- Owns the register-window pointers (read0/read1/write) internally, so REDEF no longer leaves the decoder.
- Adds a parametrised load-wait stall and a branch flush.

Parameters:
- LOAD_LAT, 1, cycles in_ready is held low after an LW is accepted (0..15; 0 = no stall).
- PAW, 2, window pointer width; REDEF supplies instr[PAW-1:0]; legal values 1..2.
- R0_DEF, 0, reset/restore value of read0 window pointer.
- R1_DEF, 1, reset/restore value of read1 window pointer.
- W_DEF, 2, reset/restore value of write window pointer.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept (combinational)
- instr  in  9  instruction: op=[8:6], fun1=[5], fun2=[5:4], redef sel=[3:2], redef val=[PAW-1:0]
- flush  in  1  branch taken; kill in-flight bundle
- out_valid  out  1  control bundle valid
- out_ready  in  1  downstream accepts bundle
- r0_sel, r1_sel, w_sel  out  PAW each  window pointers in force for this bundle
- reg_imm, reg_write_src, mem_write, mem_read, reg_write, reg_read_write, reg_write_read, is_branch  out  1 each
- alu_op  out  4  alu_op_t from definitions package
- alu_src  out  2  ALU B-source select

Behaviour:
- One clock; reset is synchronous and active-high. While reset is high:
  - all bundle outputs and out_valid = 0
  - windows = R0_DEF/R1_DEF/W_DEF
  - state = RUN, wait counter = 0
  - in_ready = 0
- Accept condition: in_valid && in_ready.
  - in_ready = !reset && state==RUN && (!out_valid || out_ready).
- Decode table is unchanged from the existing decoder:
  - REG: reg_write=1, alu_src=01, alu_op=SLB.
  - ARITH/SHIFT: reg_imm=1, reg_read_write=1, reg_write_read=1, reg_write=1; alu_op=ADD/SUB or SHIFTL/SHIFTR selected by fun1.
  - HARD fun2=LW: reg_read_write=1, reg_write=1, mem_read=1, reg_write_src=1.
  - HARD fun2=SW: reg_write_read=1, mem_write=1.
  - HARD fun2=BRANCH: reg_write_read=1, alu_op=BNZ, alu_src=10, is_branch=1.
  - SLT/XOR/AND/OR: reg_write_read=1, reg_write=1, alu_src=10, alu_op=ALU_SLT/XOR/AND/OR.
- Latency: an accepted non-REDEF instruction appears on the outputs with out_valid=1 on the next edge.
  - The bundle holds stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new instruction is accepted in the same cycle.
- REDEF (HARD, fun2=REDEF) is consumed internally and produces no bundle.
  - out_valid follows normal drain rules.
  - sel 00/01/10 writes read0/read1/write pointer = instr[PAW-1:0].
  - sel 11 restores all three pointers to their defaults.
  - The update is visible in r*_sel/w_sel of the very next accepted instruction; back-to-back REDEF then ALU must work without a bubble.
- r0_sel/r1_sel/w_sel are captured with the bundle, so later REDEFs do not alter a bundle that is already issued.
- FSM:
  - RUN: on LW accept with LOAD_LAT>0, go to LOAD_WAIT and set cnt=LOAD_LAT.
  - LOAD_WAIT: in_ready=0; cnt decrements each cycle; returns to RUN on the edge where cnt==1.
  - Result: exactly LOAD_LAT stall cycles after the accept cycle.
- flush (highest priority after reset):
  - next cycle out_valid=0.
  - Any instruction accepted in the flush cycle is discarded, including its REDEF window update and any LW wait.
  - State goes to RUN, cnt=0.
  - Window pointers retain their pre-flush values.
- Simultaneous out_ready and accept: the old bundle retires and the new bundle loads in the same edge.

Decomposition:
- Shared definitions package:
  - op_code, func_code, alu_op_t enums.
  - New dec_state_t {RUN, LOAD_WAIT}.
  - ctrl_bundle_t packed struct of all bundle signals.
  - REDEF_RESTORE=2'b11 constant.
- One sub-module: ctrl_decode_comb, the pure combinational instr -> ctrl_bundle_t table. The top holds the pipeline register, window registers, FSM and counter.

Test Plan:
- Reset, then ARITH instr 9'b001_0_xxxxx with out_ready=1 -> next cycle out_valid=1, alu_op=ADD, reg_imm=1, r0_sel=0, r1_sel=1, w_sel=2.
- REDEF sel=01 val=3, immediately followed by AND -> no bundle for REDEF; AND bundle has r1_sel=3, alu_src=10; then REDEF sel=11 -> next bundle shows defaults 0/1/2.
- LOAD_LAT=3, LW accepted at cycle t -> in_ready low for cycles t+1..t+3, high at t+4; LW bundle has mem_read=1, reg_write_src=1.
- out_ready held low 4 cycles after XOR issue -> bundle stable, in_ready=0; raise out_ready together with a new in_valid -> XOR retires and the new bundle loads on the same edge.
- flush asserted in the same cycle as a REDEF accept and with a valid LW bundle outstanding -> out_valid=0 next cycle, pointers unchanged, state RUN.
- reset asserted mid LOAD_WAIT -> next cycle all outputs 0, in_ready=1 once reset drops, windows at defaults.
